// File: rtl/fml_ddr3_arbiter_if.sv
// fml_ddr3_arbiter_if
//   Bundles the FML buses on both sides of the DDR3 arbiter.
//   m_*   : NMASTERS requesting masters, master i occupies slice i of each vector
//   s_*   : the single FML slave port of the DDR3 controller
//   grant : one-hot current owner, all-zero when idle
//   Modports:
//     slave  - the arbiter's view (takes master requests, drives the slave port)
//     master - the environment's view (masters plus DDR3 slave model)
interface fml_ddr3_arbiter_if #(
    parameter int NMASTERS  = 4,
    parameter int adr_width = 30
);
    logic [NMASTERS*adr_width-1:0] m_adr;
    logic [NMASTERS-1:0]           m_stb;
    logic [NMASTERS-1:0]           m_we;
    logic [NMASTERS*8-1:0]         m_sel;
    logic [NMASTERS*64-1:0]        m_di;
    logic [NMASTERS-1:0]           m_ack;
    logic [63:0]                   m_do;
    logic [adr_width-1:0]          s_adr;
    logic                          s_stb;
    logic                          s_we;
    logic [7:0]                    s_sel;
    logic [63:0]                   s_di;
    logic                          s_ack;
    logic [63:0]                   s_do;
    logic [NMASTERS-1:0]           grant;

    modport slave (
        input  m_adr, m_stb, m_we, m_sel, m_di, s_ack, s_do,
        output m_ack, m_do, s_adr, s_stb, s_we, s_sel, s_di, grant
    );

    modport master (
        output m_adr, m_stb, m_we, m_sel, m_di, s_ack, s_do,
        input  m_ack, m_do, s_adr, s_stb, s_we, s_sel, s_di, grant
    );
endinterface

// File: rtl/fml_ddr3_arbiter.sv
// fml_ddr3_arbiter
//   Round-robin arbiter sharing the DDR3 controller's single FML slave port
//   among NMASTERS FML masters. A grant is held for one whole transaction
//   (address phase plus BURST data beats), then the arbiter returns to IDLE
//   for one cycle and re-arbitrates starting after the last owner.
//   Ports:
//     sys_clk   - system clock, rising edge
//     sys_rst_n - asynchronous active-low reset
//     bus       - fml_ddr3_arbiter_if.slave (master buses, slave port, grant)
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | no owner; pick first requester upward from rr pointer
//   ADDR   | owner's adr/we/stb routed to slave, waiting for s_ack
//   DATA   | BURST beats of sel/di out and s_do in, then release
module fml_ddr3_arbiter #(
    parameter int NMASTERS  = 4,
    parameter int adr_width = 30,
    parameter int BURST     = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    fml_ddr3_arbiter_if.slave    bus
);
    localparam int PW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
    localparam int CW = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [NMASTERS-1:0] grant_q, grant_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       beat_q, beat_d;

    logic [PW-1:0]       gidx;
    logic [PW-1:0]       gidx_next;
    logic [PW-1:0]       win_idx;
    logic                win_found;

    // Binary index of the current one-hot owner.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NMASTERS; i++) begin
            if (grant_q[i]) gidx = PW'(i);
        end
    end

    // Pointer value after the owner finishes; explicit wrap since NMASTERS
    // need not be a power of two.
    assign gidx_next = (int'(gidx) == NMASTERS - 1) ? '0 : gidx + PW'(1);

    // First requester searching upward from the pointer, wrapping.
    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NMASTERS; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NMASTERS) cand = cand - NMASTERS;
            if (!win_found && bus.m_stb[cand]) begin
                win_found = 1'b1;
                win_idx   = PW'(cand);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    state_d          = S_ADDR;
                end
            end
            S_ADDR: begin
                // An ack takes precedence over a strobe withdrawn in the same cycle.
                if (bus.s_ack) begin
                    state_d = S_DATA;
                    beat_d  = '0;
                end else if (!bus.m_stb[gidx]) begin
                    // Abandoned request: rotation does not advance.
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            end
            S_DATA: begin
                beat_d = beat_q + CW'(1);
                if (beat_q == CW'(BURST - 1)) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    ptr_d   = gidx_next;
                    beat_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
        end
    end

    // Slave-side muxing is gated by state so nothing leaks outside its phase;
    // in particular s_sel stays zero outside DATA to avoid stray byte writes.
    logic in_addr, in_data;
    assign in_addr = (state_q == S_ADDR);
    assign in_data = (state_q == S_DATA);

    assign bus.s_stb = in_addr & bus.m_stb[gidx];
    assign bus.s_we  = in_addr & bus.m_we[gidx];
    assign bus.s_adr = in_addr ? bus.m_adr[int'(gidx)*adr_width +: adr_width] : '0;
    assign bus.s_sel = in_data ? bus.m_sel[int'(gidx)*8 +: 8] : '0;
    assign bus.s_di  = in_data ? bus.m_di[int'(gidx)*64 +: 64] : '0;
    assign bus.m_ack = (in_addr && bus.s_ack) ? grant_q : '0;
    assign bus.m_do  = bus.s_do;
    assign bus.grant = grant_q;
endmodule
